// File: rtl/sdr_bridge_pkg.sv
// Shared types and constants for the sdr_* conduit responder.
package sdr_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RD_RUN,
        RD_DRAIN,
        WR_RUN,
        DONE
    } sdr_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } sdr_op_t;

    localparam int SDR_NELEMS_W   = 30;
    localparam int SDR_WORD_BYTES = 4;

endpackage

// File: rtl/sdr_burst_responder.sv
// Responder for the sdr_* conduit: turns read/write start pulses into word-by-word
// Avalon-MM master transfers, unpacking reads into a wide registered buffer.
module sdr_burst_responder
    import sdr_bridge_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int WORD_W   = 32,
    parameter int NWORDS   = 64,
    parameter int MAX_PEND = 8
) (
    input  logic                       sdr_clk,
    input  logic                       sdr_reset_n,
    input  logic                       sdr_readstart,
    input  logic                       sdr_writestart,
    input  logic [ADDR_W-1:0]          sdr_baseaddr,
    input  logic [SDR_NELEMS_W-1:0]    sdr_nelems,
    input  logic [NWORDS*WORD_W-1:0]   sdr_writedata,
    output logic [NWORDS*WORD_W-1:0]   sdr_readdata,
    output logic                       sdr_readend,
    output logic                       sdr_writeend,
    output logic [ADDR_W-1:0]          avm_address,
    output logic                       avm_read,
    output logic                       avm_write,
    output logic [WORD_W-1:0]          avm_writedata,
    output logic [WORD_W/8-1:0]        avm_byteenable,
    input  logic                       avm_waitrequest,
    input  logic [WORD_W-1:0]          avm_readdata,
    input  logic                       avm_readdatavalid
);

    localparam int CNT_W  = $clog2(NWORDS + 1);
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int PEND_W = $clog2(MAX_PEND + 1);
    localparam int BUF_W  = NWORDS * WORD_W;

    sdr_state_t        state_q, state_d;
    sdr_op_t           op_q, op_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [CNT_W-1:0]  r_q, r_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [BUF_W-1:0]  rbuf_q, rbuf_d;

    logic              rd_accept;
    logic              ret_accept;
    logic [CNT_W-1:0]  n_clamped;

    function automatic logic [CNT_W-1:0] clamp_count(input logic [SDR_NELEMS_W-1:0] nel);
        if (nel > SDR_NELEMS_W'(NWORDS)) begin
            return CNT_W'(NWORDS);
        end
        return nel[CNT_W-1:0];
    endfunction

    // Address arithmetic wraps modulo 2^ADDR_W by truncation.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
        return base + ADDR_W'(idx) * ADDR_W'(SDR_WORD_BYTES);
    endfunction

    assign n_clamped      = clamp_count(sdr_nelems);
    assign avm_byteenable = '1;
    assign sdr_readdata   = rbuf_q;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        base_d        = base_q;
        n_d           = n_q;
        k_d           = k_q;
        r_d           = r_q;
        pend_d        = pend_q;
        rbuf_d        = rbuf_q;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_address   = '0;
        avm_writedata = '0;
        sdr_readend   = 1'b0;
        sdr_writeend  = 1'b0;
        rd_accept     = 1'b0;

        // A return with nothing outstanding can only be a leftover from an aborted run.
        ret_accept = avm_readdatavalid
                     && ((state_q == RD_RUN) || (state_q == RD_DRAIN))
                     && (r_q < n_q)
                     && (pend_q != '0);

        if (ret_accept) begin
            rbuf_d[WORD_W*r_q[IDX_W-1:0] +: WORD_W] = avm_readdata;
            r_d = r_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (sdr_readstart) begin
                    op_d    = OP_READ;
                    state_d = ARM;
                end else if (sdr_writestart) begin
                    op_d    = OP_WRITE;
                    state_d = ARM;
                end
            end

            ARM: begin
                base_d = sdr_baseaddr;
                n_d    = n_clamped;
                k_d    = '0;
                r_d    = '0;
                pend_d = '0;
                if (n_clamped == '0) begin
                    state_d = DONE;
                end else if (op_q == OP_READ) begin
                    state_d = RD_RUN;
                end else begin
                    state_d = WR_RUN;
                end
            end

            RD_RUN: begin
                avm_read    = (pend_q != PEND_W'(MAX_PEND));
                avm_address = word_addr(base_q, k_q);
                rd_accept   = avm_read && !avm_waitrequest;
                if (rd_accept) begin
                    k_d = k_q + CNT_W'(1);
                    if (k_q + CNT_W'(1) == n_q) begin
                        state_d = RD_DRAIN;
                    end
                end
            end

            RD_DRAIN: begin
                if (r_d == n_q) begin
                    state_d = DONE;
                end
            end

            WR_RUN: begin
                avm_write     = 1'b1;
                avm_address   = word_addr(base_q, k_q);
                avm_writedata = sdr_writedata[WORD_W*k_q[IDX_W-1:0] +: WORD_W];
                if (!avm_waitrequest) begin
                    k_d = k_q + CNT_W'(1);
                    if (k_q + CNT_W'(1) == n_q) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                sdr_readend  = (op_q == OP_READ);
                sdr_writeend = (op_q == OP_WRITE);
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        case ({rd_accept, ret_accept})
            2'b10:   pend_d = pend_q + PEND_W'(1);
            2'b01:   pend_d = pend_q - PEND_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge sdr_clk or negedge sdr_reset_n) begin
        if (!sdr_reset_n) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            base_q  <= '0;
            n_q     <= '0;
            k_q     <= '0;
            r_q     <= '0;
            pend_q  <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            base_q  <= base_d;
            n_q     <= n_d;
            k_q     <= k_d;
            r_q     <= r_d;
            pend_q  <= pend_d;
            rbuf_q  <= rbuf_d;
        end
    end

endmodule
